// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: access-size encodings,
// FSM state type, wait-counter width and byte-lane helper functions.
package mem_pkg;

  typedef enum logic [1:0] {
    BSEL_WORD     = 2'b00,
    BSEL_HALF     = 2'b01,
    BSEL_BYTE     = 2'b10,
    BSEL_WORD_ALT = 2'b11
  } byte_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int WAIT_CNT_W = 4;

  function automatic logic is_misaligned(input logic [1:0] bsel, input logic [1:0] lo);
    logic bad;
    case (bsel)
      BSEL_HALF: bad = lo[0];
      BSEL_BYTE: bad = 1'b0;
      default:   bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] bsel, input logic [1:0] lo);
    logic [3:0] be;
    case (bsel)
      BSEL_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      BSEL_BYTE: be = 4'b0001 << lo;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Word-organised storage: synchronous write with per-byte enables, asynchronous read.
// Contents are intentionally not reset.
module mem_word_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Byte-lane masked write
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// CPU-side data memory responder: accepts one request, waits WAIT_STATES cycles,
// strobes Ack with the load result / error, and commits stores on leaving RESP.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [1:0]  ByteSel,
  input  logic        Unsigned,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic        Ack,
  output logic [31:0] ReadData,
  output logic        Err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

  state_e                state_r;
  logic [WAIT_CNT_W-1:0] cnt_r;
  logic [AW+1:0]         addr_r;
  logic [31:0]           wdata_r;
  logic [1:0]            bsel_r;
  logic                  uns_r, rd_r, wr_r;
  logic                  ack_r, err_r;
  logic [31:0]           rdata_r;

  logic [AW+1:0] sel_addr_s;
  logic [1:0]    sel_bsel_s;
  logic          sel_uns_s, sel_rd_s, sel_wr_s;
  logic [31:0]   rd_word_s, load_s, resp_data_s, wlane_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic          err_s, we_s;
  logic [3:0]    be_s;
  logic          unused_addr_s;

  assign unused_addr_s = ^Address[31:AW+2];

  // In IDLE the response is formed from live inputs (zero-wait case); otherwise from the latched copy
  always_comb begin
    sel_addr_s = addr_r;
    sel_bsel_s = bsel_r;
    sel_uns_s  = uns_r;
    sel_rd_s   = rd_r;
    sel_wr_s   = wr_r;
    if (state_r == ST_IDLE) begin
      sel_addr_s = Address[AW+1:0];
      sel_bsel_s = ByteSel;
      sel_uns_s  = Unsigned;
      sel_rd_s   = MemRead;
      sel_wr_s   = MemWrite;
    end else begin
      sel_addr_s = addr_r;
    end
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    case (sel_addr_s[1:0])
      2'b00:   byte_s = rd_word_s[7:0];
      2'b01:   byte_s = rd_word_s[15:8];
      2'b10:   byte_s = rd_word_s[23:16];
      default: byte_s = rd_word_s[31:24];
    endcase
    half_s = sel_addr_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];
    case (sel_bsel_s)
      BSEL_BYTE: load_s = sel_uns_s ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
      BSEL_HALF: load_s = sel_uns_s ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      default:   load_s = rd_word_s;
    endcase
    err_s       = is_misaligned(sel_bsel_s, sel_addr_s[1:0]) || (sel_rd_s == sel_wr_s);
    resp_data_s = (err_s || !sel_rd_s) ? 32'h0000_0000 : load_s;
  end

  // Store path uses only the latched request; committed on the edge leaving RESP
  always_comb begin
    case (bsel_r)
      BSEL_BYTE: wlane_s = {4{wdata_r[7:0]}};
      BSEL_HALF: wlane_s = {2{wdata_r[15:0]}};
      default:   wlane_s = wdata_r;
    endcase
    be_s = lane_enables(bsel_r, addr_r[1:0]);
    we_s = Rst && (state_r == ST_RESP) && wr_r && !rd_r && !is_misaligned(bsel_r, addr_r[1:0]);
  end

  mem_word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (Clk),
    .we   (we_s),
    .be   (be_s),
    .waddr(addr_r[AW+1:2]),
    .wdata(wlane_s),
    .raddr(sel_addr_s[AW+1:2]),
    .rdata(rd_word_s)
  );

  // Request FSM with registered response outputs
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
      bsel_r  <= 2'b00;
      uns_r   <= 1'b0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          rdata_r <= 32'h0000_0000;
          if (Req) begin
            addr_r  <= Address[AW+1:0];
            wdata_r <= WriteData;
            bsel_r  <= ByteSel;
            uns_r   <= Unsigned;
            rd_r    <= MemRead;
            wr_r    <= MemWrite;
            if (WAIT_STATES == 0) begin
              state_r <= ST_RESP;
              cnt_r   <= '0;
              ack_r   <= 1'b1;
              err_r   <= err_s;
              rdata_r <= resp_data_s;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= WAIT_INIT;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r <= CNT_ONE) begin
            state_r <= ST_RESP;
            cnt_r   <= '0;
            ack_r   <= 1'b1;
            err_r   <= err_s;
            rdata_r <= resp_data_s;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          rdata_r <= 32'h0000_0000;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          rdata_r <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign Ack      = ack_r;
  assign Err      = err_r;
  assign ReadData = rdata_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: one instance with one wait
// state for the functional scenarios, one with zero wait states for back-to-back.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, uns, mrd, mwr, ack, err;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  bsel;

  logic        rst0, req0, uns0, mrd0, mwr0, ack0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [1:0]  bsel0;

  int checks = 0;
  int fails  = 0;

  int          t_cyc;
  logic [31:0] t_data, t_data_after;
  logic        t_err, t_ack_after;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut (
    .Clk(clk), .Rst(rst), .Req(req), .Address(addr), .WriteData(wdata),
    .ByteSel(bsel), .Unsigned(uns), .MemWrite(mwr), .MemRead(mrd),
    .Ack(ack), .ReadData(rdata), .Err(err)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .Clk(clk), .Rst(rst0), .Req(req0), .Address(addr0), .WriteData(wdata0),
    .ByteSel(bsel0), .Unsigned(uns0), .MemWrite(mwr0), .MemRead(mrd0),
    .Ack(ack0), .ReadData(rdata0), .Err(err0)
  );

  // Issue one request on u_dut and capture the Ack cycle, response and the cycle after
  task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] bs,
                        input logic u, input logic r, input logic w);
    @(negedge clk);
    addr = a; wdata = d; bsel = bs; uns = u; mrd = r; mwr = w; req = 1'b1;
    t_cyc = 0; t_data = 'x; t_err = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        t_cyc = i; t_data = rdata; t_err = err;
        break;
      end
    end
    req = 1'b0;
    if (t_cyc == 0) begin
      fails++; checks++;
      $display("FAIL txn_timeout addr=%h: no Ack within 40 cycles", a);
    end
    @(posedge clk); #1;
    t_ack_after = ack; t_data_after = rdata;
  endtask

  task automatic test_reset;
    rst = 1'b0; req = 1'b0; addr = 32'h0; wdata = 32'h0; bsel = 2'b00; uns = 1'b0;
    mrd = 1'b0; mwr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", ack); end
    checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_word;
    do_txn(32'h10, 32'hDEADBEEF, 2'b00, 1'b0, 1'b0, 1'b1);
    checks++; if (t_cyc != 2) begin fails++; $display("FAIL word_st_latency: got %0d want 2", t_cyc); end
    checks++; if (t_err !== 1'b0) begin fails++; $display("FAIL word_st_err: got %b want 0", t_err); end
    do_txn(32'h10, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    checks++; if (t_cyc != 2) begin fails++; $display("FAIL word_ld_latency: got %0d want 2", t_cyc); end
    checks++; if (t_data !== 32'hDEADBEEF) begin fails++; $display("FAIL word_ld_data: got %h want deadbeef", t_data); end
    checks++; if (t_err !== 1'b0) begin fails++; $display("FAIL word_ld_err: got %b want 0", t_err); end
    checks++; if (t_ack_after !== 1'b0) begin fails++; $display("FAIL ack_one_cycle: got %b want 0", t_ack_after); end
    checks++; if (t_data_after !== 32'h0) begin fails++; $display("FAIL rdata_idle: got %h want 0", t_data_after); end
  endtask

  task automatic test_byte_half;
    do_txn(32'h10, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    do_txn(32'h11, 32'h000000AB, 2'b10, 1'b0, 1'b0, 1'b1);
    do_txn(32'h10, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    checks++; if (t_data !== 32'h0000AB00) begin fails++; $display("FAIL byte_st_word_ld: got %h want 0000ab00", t_data); end
    do_txn(32'h11, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0);
    checks++; if (t_data !== 32'hFFFFFFAB) begin fails++; $display("FAIL byte_ld_signed: got %h want ffffffab", t_data); end
    do_txn(32'h11, 32'h0, 2'b10, 1'b1, 1'b1, 1'b0);
    checks++; if (t_data !== 32'h000000AB) begin fails++; $display("FAIL byte_ld_unsigned: got %h want 000000ab", t_data); end
    do_txn(32'h12, 32'h00008001, 2'b01, 1'b0, 1'b0, 1'b1);
    do_txn(32'h10, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    checks++; if (t_data !== 32'h8001AB00) begin fails++; $display("FAIL half_st_word_ld: got %h want 8001ab00", t_data); end
    do_txn(32'h12, 32'h0, 2'b01, 1'b0, 1'b1, 1'b0);
    checks++; if (t_data !== 32'hFFFF8001) begin fails++; $display("FAIL half_ld_signed: got %h want ffff8001", t_data); end
    do_txn(32'h10, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0);
    checks++; if (t_data !== 32'h0000AB00) begin fails++; $display("FAIL half_ld_unsigned: got %h want 0000ab00", t_data); end
  endtask

  task automatic test_misaligned;
    do_txn(32'h13, 32'h0, 2'b01, 1'b0, 1'b1, 1'b0);
    checks++; if (t_err !== 1'b1) begin fails++; $display("FAIL half_mis_err: got %b want 1", t_err); end
    checks++; if (t_data !== 32'h0) begin fails++; $display("FAIL half_mis_data: got %h want 0", t_data); end
    do_txn(32'h12, 32'h12345678, 2'b00, 1'b0, 1'b0, 1'b1);
    checks++; if (t_err !== 1'b1) begin fails++; $display("FAIL word_mis_err: got %b want 1", t_err); end
    do_txn(32'h10, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    checks++; if (t_data !== 32'h8001AB00) begin fails++; $display("FAIL word_mis_nowrite: got %h want 8001ab00", t_data); end
  endtask

  task automatic test_bad_op;
    do_txn(32'h10, 32'hFFFFFFFF, 2'b00, 1'b0, 1'b1, 1'b1);
    checks++; if (t_cyc != 2) begin fails++; $display("FAIL badop_latency: got %0d want 2", t_cyc); end
    checks++; if (t_err !== 1'b1) begin fails++; $display("FAIL badop_both_err: got %b want 1", t_err); end
    checks++; if (t_data !== 32'h0) begin fails++; $display("FAIL badop_both_data: got %h want 0", t_data); end
    do_txn(32'h10, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++; if (t_err !== 1'b1) begin fails++; $display("FAIL badop_none_err: got %b want 1", t_err); end
    do_txn(32'h10, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    checks++; if (t_data !== 32'h8001AB00) begin fails++; $display("FAIL badop_nowrite: got %h want 8001ab00", t_data); end
  endtask

  task automatic test_ignore_inputs;
    logic seen;
    @(negedge clk);
    addr = 32'h11; wdata = 32'h0; bsel = 2'b10; uns = 1'b0; mrd = 1'b1; mwr = 1'b0; req = 1'b1;
    @(posedge clk); #1;
    addr = 32'h10; bsel = 2'b00; uns = 1'b1; mrd = 1'b0; mwr = 1'b1;
    @(posedge clk); #1;
    seen = ack;
    checks++; if (seen !== 1'b1) begin fails++; $display("FAIL ignore_ack: got %b want 1", seen); end
    checks++; if (rdata !== 32'hFFFFFFAB) begin fails++; $display("FAIL ignore_data: got %h want ffffffab", rdata); end
    req = 1'b0;
    @(posedge clk); #1;
    do_txn(32'h10, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    checks++; if (t_data !== 32'h8001AB00) begin fails++; $display("FAIL ignore_nowrite: got %h want 8001ab00", t_data); end
  endtask

  task automatic test_reset_abort;
    logic any_ack;
    @(negedge clk);
    addr = 32'h10; wdata = 32'hCAFEF00D; bsel = 2'b00; uns = 1'b0; mrd = 1'b0; mwr = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin fails++; $display("FAIL abort_ack: got %b want 0", ack); end
    checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL abort_rdata: got %h want 0", rdata); end
    @(negedge clk); rst = 1'b1;
    any_ack = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack === 1'b1) any_ack = 1'b1;
    end
    checks++; if (any_ack !== 1'b0) begin fails++; $display("FAIL abort_late_ack: got %b want 0", any_ack); end
    do_txn(32'h10, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    checks++; if (t_data !== 32'h8001AB00) begin fails++; $display("FAIL abort_nowrite: got %h want 8001ab00", t_data); end
  endtask

  task automatic test_back_to_back;
    rst0 = 1'b0; req0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; bsel0 = 2'b00; uns0 = 1'b0;
    mrd0 = 1'b0; mwr0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst0 = 1'b1;
    @(negedge clk);
    addr0 = 32'h1000; wdata0 = 32'h11223344; mrd0 = 1'b0; mwr0 = 1'b1; req0 = 1'b1;
    @(posedge clk); #1;
    checks++; if (ack0 !== 1'b1) begin fails++; $display("FAIL b2b_ack1: got %b want 1", ack0); end
    checks++; if (err0 !== 1'b0) begin fails++; $display("FAIL b2b_err1: got %b want 0", err0); end
    @(negedge clk);
    addr0 = 32'h0; wdata0 = 32'h0; mrd0 = 1'b1; mwr0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack0 !== 1'b0) begin fails++; $display("FAIL b2b_gap1: got %b want 0", ack0); end
    @(posedge clk); #1;
    checks++; if (ack0 !== 1'b1) begin fails++; $display("FAIL b2b_ack2: got %b want 1", ack0); end
    checks++; if (rdata0 !== 32'h11223344) begin fails++; $display("FAIL b2b_alias_data: got %h want 11223344", rdata0); end
    @(negedge clk);
    addr0 = 32'h1000;
    @(posedge clk); #1;
    checks++; if (ack0 !== 1'b0) begin fails++; $display("FAIL b2b_gap2: got %b want 0", ack0); end
    @(posedge clk); #1;
    checks++; if (ack0 !== 1'b1) begin fails++; $display("FAIL b2b_ack3: got %b want 1", ack0); end
    checks++; if (rdata0 !== 32'h11223344) begin fails++; $display("FAIL b2b_data3: got %h want 11223344", rdata0); end
    req0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack0 !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b want 0", ack0); end
  endtask

  initial begin
    rst0 = 1'b0; req0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; bsel0 = 2'b00;
    uns0 = 1'b0; mrd0 = 1'b0; mwr0 = 1'b0;
    test_reset();
    test_word();
    test_byte_half();
    test_misaligned();
    test_bad_op();
    test_ignore_inputs();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles between request acceptance and Ack (0..15).
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port Rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port Req  input  1  request valid from CPU side; fields below stable while high.
REQ-006 SHALL have port Address  input  32  byte address.
REQ-007 SHALL have port WriteData  input  32  store data, right-justified for byte/half.
REQ-008 SHALL have port ByteSel  input  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-009 SHALL have port Unsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
REQ-010 SHALL have ports MemWrite, MemRead  input  1 each  operation select.
REQ-011 SHALL have port Ack  output  1  one-cycle response strobe.
REQ-012 SHALL have port ReadData  output  32  load result, valid only while Ack=1.
REQ-013 SHALL have port Err  output  1  error flag, valid only while Ack=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 In IDLE with Req=1 SHALL latch Address, WriteData, ByteSel, Unsigned, MemRead, MemWrite; go WAIT with counter=WAIT_STATES, or RESP directly if WAIT_STATES=0.
REQ-016 In IDLE with Req=0 SHALL remain IDLE; Ack=0.
REQ-017 WAIT SHALL decrement counter each cycle and go RESP on the cycle counter reaches 1.
REQ-018 Ack SHALL be 1 exactly during RESP, i.e. in cycle WAIT_STATES+1 after the accepting edge; RESP always returns to IDLE.
REQ-019 Requester SHALL drop Req on the edge where it samples Ack=1; Req still high in IDLE is a new request.
REQ-020 Input changes during WAIT/RESP SHALL be ignored (latched copy used).
REQ-021 Word index SHALL be Address[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap modulo DEPTH_WORDS*4).
REQ-022 Byte lanes little-endian: Address[1:0]=0 selects bits 7:0.
REQ-023 Store SHALL write only addressed lanes on the edge leaving RESP: byte -> 1 lane, half -> lanes {1,0} or {3,2}, word -> all.
REQ-024 Load SHALL return addressed byte/half extended per Unsigned; word returned unchanged.
REQ-025 Misaligned access (half with Address[0]=1, word with Address[1:0]!=0) SHALL give Err=1, ReadData=0, no write.
REQ-026 MemRead=MemWrite=1 or MemRead=MemWrite=0 SHALL give Err=1, ReadData=0, no write, normal latency.
REQ-027 ReadData and Err SHALL be 0 whenever Ack=0.
REQ-028 A read returning in RESP SHALL reflect all writes completed on earlier edges.

Reset
REQ-029 Rst=0 at a rising edge SHALL force IDLE, counter=0, Ack=0, Err=0, ReadData=0, regardless of state.
REQ-030 Reset mid-operation SHALL abort the transaction without writing memory; no Ack issued for it.
REQ-031 Memory contents SHALL NOT be cleared by reset (undefined until written).

Structure
REQ-032 Shared package mem_pkg SHALL hold ByteSel encodings, FSM state type, WAIT counter width.
REQ-033 Storage SHALL be sub-module mem_word_ram: DEPTH_WORDS x 32, synchronous write with 4 byte enables, asynchronous read.
REQ-034 Lane/extension logic and FSM SHALL reside in data_mem_responder.

Verification
REQ-035 Word store 0xDEADBEEF @0x10, then word load @0x10 -> Ack in cycle 2 after acceptance (WAIT_STATES=1), ReadData=0xDEADBEEF, Err=0.
REQ-036 Byte store 0x000000AB @0x11 over word 0x00000000, word load @0x10 -> 0x0000AB00; signed byte load @0x11 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-037 Half load @0x13 -> Err=1, ReadData=0; word store @0x12 -> Err=1, subsequent load @0x10 unchanged.
REQ-038 Req with MemRead=MemWrite=1 -> Ack after normal latency, Err=1, memory unchanged.
REQ-039 Store accepted, Rst=0 during WAIT -> no Ack, next load of that address returns prior value; Ack=0, ReadData=0 after reset.
REQ-040 WAIT_STATES=0, back-to-back Req held one cycle after Ack -> second transaction accepted, Ack every 2 cycles; store @0x1000 with DEPTH_WORDS=1024 aliases load @0x0.
